// File: rtl/frogger_pkg.sv
// Shared constants and state encoding for the frogger collision logic.
// Screen geometry defaults live here so every row stage agrees on them.
package frogger_pkg;

  localparam int SCREEN_W = 640;
  localparam int ROW_H    = 32;
  localparam int CAR_W    = 64;
  localparam int FROG_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT,
    HOLD
  } coll_state_t;

endpackage

// File: rtl/wrap_overlap.sv
// Horizontal overlap test between frog and one car on a circular screen.
// Either left edge at or beyond SCREEN_W never overlaps.
module wrap_overlap #(
  parameter int SCREEN_W = frogger_pkg::SCREEN_W,
  parameter int CAR_W    = frogger_pkg::CAR_W,
  parameter int FROG_W   = frogger_pkg::FROG_W
) (
  input  logic [10:0] f,
  input  logic [10:0] c,
  output logic        hit
);

  localparam logic signed [11:0] SW_S   = 12'(SCREEN_W);
  localparam logic signed [11:0] CAR_S  = 12'(CAR_W);
  localparam logic signed [11:0] FROG_S = 12'(FROG_W);

  // (a - b) mod SCREEN_W for in-range operands; 12 bits holds the full span.
  function automatic logic signed [11:0] wrap_diff(input logic [10:0] a,
                                                   input logic [10:0] b);
    logic signed [11:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = d + SW_S;
    return d;
  endfunction

  logic signed [11:0] dfc;
  logic signed [11:0] dcf;
  logic               in_range;

  always_comb begin
    dfc      = wrap_diff(f, c);
    dcf      = wrap_diff(c, f);
    in_range = ({1'b0, f} < 12'(SCREEN_W)) && ({1'b0, c} < 12'(SCREEN_W));
    hit      = in_range && ((dfc < CAR_S) || (dcf < FROG_S));
  end

endmodule

// File: rtl/car_collide.sv
// Per-row frog/car collision detector: snapshots a row on each frame tick,
// scans cars one per clock through a shared comparator and holds hits until acked.
module car_collide
  import frogger_pkg::*;
#(
  parameter int NUM_CARS = 4,
  parameter int CAR_W    = frogger_pkg::CAR_W,
  parameter int FROG_W   = frogger_pkg::FROG_W,
  parameter int ROW_H    = frogger_pkg::ROW_H,
  parameter int SCREEN_W = frogger_pkg::SCREEN_W
) (
  input  logic                                               Clk,
  input  logic                                               Reset,
  input  logic                                               frame_clk,
  input  logic [NUM_CARS-1:0][10:0]                          Car_X,
  input  logic [NUM_CARS-1:0]                                Car_Valid,
  input  logic [10:0]                                        CarY,
  input  logic [10:0]                                        FrogX,
  input  logic [10:0]                                        FrogY,
  input  logic                                               Hit_Ack,
  output logic                                               Frog_Hit,
  output logic [(NUM_CARS > 1 ? $clog2(NUM_CARS) : 1)-1:0]   Hit_Car,
  output logic                                               Busy,
  output logic                                               Overrun
);

  localparam int HC_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam logic [HC_W-1:0] LAST_IDX = HC_W'(NUM_CARS - 1);

  coll_state_t state_q, state_d;
  logic            fc_q, fc_d;
  logic [HC_W-1:0] idx_q, idx_d;
  logic            hit_found_q, hit_found_d;
  logic [HC_W-1:0] hit_idx_q, hit_idx_d;
  logic            frog_hit_q, frog_hit_d;
  logic [HC_W-1:0] hit_car_q, hit_car_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  logic [NUM_CARS-1:0][10:0] car_x_q, car_x_d;
  logic [NUM_CARS-1:0]       car_valid_q, car_valid_d;
  logic [10:0]               car_y_q, car_y_d;
  logic [10:0]               frog_x_q, frog_x_d;
  logic [10:0]               frog_y_q, frog_y_d;

  logic start;
  logic v_match;
  logic h_hit;
  logic car_hit;

  wrap_overlap #(
    .SCREEN_W (SCREEN_W),
    .CAR_W    (CAR_W),
    .FROG_W   (FROG_W)
  ) u_overlap (
    .f   (frog_x_q),
    .c   (car_x_q[idx_q]),
    .hit (h_hit)
  );

  always_comb begin
    start   = frame_clk & ~fc_q;
    v_match = ({1'b0, frog_y_q} >= {1'b0, car_y_q}) &&
              ({1'b0, frog_y_q} < ({1'b0, car_y_q} + 12'(ROW_H)));
    car_hit = car_valid_q[idx_q] & v_match & h_hit;

    state_d     = state_q;
    fc_d        = frame_clk;
    idx_d       = idx_q;
    hit_found_d = hit_found_q;
    hit_idx_d   = hit_idx_q;
    frog_hit_d  = frog_hit_q;
    hit_car_d   = hit_car_q;
    overrun_d   = overrun_q;
    car_x_d     = car_x_q;
    car_valid_d = car_valid_q;
    car_y_d     = car_y_q;
    frog_x_d    = frog_x_q;
    frog_y_d    = frog_y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          car_x_d     = Car_X;
          car_valid_d = Car_Valid;
          car_y_d     = CarY;
          frog_x_d    = FrogX;
          frog_y_d    = FrogY;
          idx_d       = '0;
          hit_found_d = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (car_hit && !hit_found_q) begin
          hit_idx_d   = idx_q;
          hit_found_d = 1'b1;
        end
        if (idx_q == LAST_IDX) state_d = REPORT;
        else                   idx_d   = idx_q + HC_W'(1);
      end
      REPORT: begin
        if (hit_found_q) begin
          frog_hit_d = 1'b1;
          hit_car_d  = hit_idx_q;
          state_d    = HOLD;
        end else begin
          frog_hit_d = 1'b0;
          state_d    = IDLE;
        end
      end
      HOLD: begin
        if (Hit_Ack) begin
          frog_hit_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Edges outside IDLE are dropped but remembered.
    if (start && (state_q != IDLE)) overrun_d = 1'b1;

    busy_d = (state_d == SCAN) || (state_d == REPORT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      fc_q        <= frame_clk;
      idx_q       <= '0;
      hit_found_q <= 1'b0;
      hit_idx_q   <= '0;
      frog_hit_q  <= 1'b0;
      hit_car_q   <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      idx_q       <= idx_d;
      hit_found_q <= hit_found_d;
      hit_idx_q   <= hit_idx_d;
      frog_hit_q  <= frog_hit_d;
      hit_car_q   <= hit_car_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Snapshot registers carry data only; they are always loaded before use.
  always_ff @(posedge Clk) begin
    car_x_q     <= car_x_d;
    car_valid_q <= car_valid_d;
    car_y_q     <= car_y_d;
    frog_x_q    <= frog_x_d;
    frog_y_q    <= frog_y_d;
  end

  assign Frog_Hit = frog_hit_q;
  assign Hit_Car  = hit_car_q;
  assign Busy     = busy_q;
  assign Overrun  = overrun_q;

endmodule

// File: tb/tb_car_collide.sv
// Table-driven bench for car_collide with a scoreboard queue of expected scan results.
module tb_car_collide;

  localparam int NC = 4;
  localparam int NV = 19;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 frame_clk;
  logic [NC-1:0][10:0]  Car_X;
  logic [NC-1:0]        Car_Valid;
  logic [10:0]          CarY;
  logic [10:0]          FrogX;
  logic [10:0]          FrogY;
  logic                 Hit_Ack;
  logic                 Frog_Hit;
  logic [1:0]           Hit_Car;
  logic                 Busy;
  logic                 Overrun;

  car_collide #(.NUM_CARS(NC)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .Car_X     (Car_X),
    .Car_Valid (Car_Valid),
    .CarY      (CarY),
    .FrogX     (FrogX),
    .FrogY     (FrogY),
    .Hit_Ack   (Hit_Ack),
    .Frog_Hit  (Frog_Hit),
    .Hit_Car   (Hit_Car),
    .Busy      (Busy),
    .Overrun   (Overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [NC-1:0][10:0] cx;
    logic [NC-1:0]       vld;
    logic [10:0]         cy;
    logic [10:0]         fx;
    logic [10:0]         fy;
    logic                hit;
    logic [1:0]          car;
    string               name;
  } vec_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] car;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[NV];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                              input logic [3:0] vld, input int cy, input int fx,
                              input int fy, input logic hit, input int car,
                              input string name);
    vec_t v;
    v.cx[0] = 11'(c0);
    v.cx[1] = 11'(c1);
    v.cx[2] = 11'(c2);
    v.cx[3] = 11'(c3);
    v.vld   = vld;
    v.cy    = 11'(cy);
    v.fx    = 11'(fx);
    v.fy    = 11'(fy);
    v.hit   = hit;
    v.car   = 2'(car);
    v.name  = name;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    Car_X     = v.cx;
    Car_Valid = v.vld;
    CarY      = v.cy;
    FrogX     = v.fx;
    FrogY     = v.fy;
  endtask

  // Junk inputs after the snapshot edge; the scan must ignore them.
  task automatic scramble();
    Car_Valid = ~Car_Valid;
    FrogX     = FrogX ^ 11'h0AA;
    FrogY     = CarY + 11'd5;
    for (int i = 0; i < NC; i++) Car_X[i] = Car_X[i] ^ 11'h055;
  endtask

  // Starts a scan on the current negedge; re_edge > 0 raises a second edge at that negedge.
  task automatic run_vec(input vec_t v, input int re_edge);
    exp_t e;
    int   cyc;
    bit   done;
    drive(v);
    frame_clk = 1'b1;
    e.hit = v.hit;
    e.car = v.car;
    exp_q.push_back(e);
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 20) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        frame_clk = 1'b0;
        chk({v.name, " busy"}, 32'(Busy), 32'd1);
        scramble();
      end else if (!Busy) begin
        done = 1'b1;
      end
      if (re_edge > 0 && cyc == re_edge) begin
        chk({v.name, " overrun_pre"}, 32'(Overrun), 32'd0);
        frame_clk = 1'b1;
      end
      if (re_edge > 0 && cyc == re_edge + 1) begin
        chk({v.name, " overrun_set"}, 32'(Overrun), 32'd1);
        frame_clk = 1'b0;
      end
    end
    chk({v.name, " done"}, 32'(done), 32'd1);
    chk({v.name, " latency"}, 32'(cyc), 32'd6);
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard: got empty queue, expected one entry", v.name);
      n_err++;
      n_cmp++;
    end else begin
      e = exp_q.pop_front();
      chk({v.name, " frog_hit"}, 32'(Frog_Hit), 32'(e.hit));
      if (e.hit) begin
        chk({v.name, " hit_car"}, 32'(Hit_Car), 32'(e.car));
        repeat (2) @(negedge Clk);
        chk({v.name, " hold"}, 32'(Frog_Hit), 32'd1);
        Hit_Ack = 1'b1;
        @(negedge Clk);
        Hit_Ack = 1'b0;
        chk({v.name, " ack_clear"}, 32'(Frog_Hit), 32'd0);
      end
    end
    @(negedge Clk);
  endtask

  initial begin
    vecs[0]  = mk(0, 150, 400, 600, 4'hF, 100, 200, 110, 1, 1, "basic");
    vecs[1]  = mk(600, 0, 0, 0, 4'h1, 100, 10, 110, 1, 0, "wrap_dfc");
    vecs[2]  = mk(0, 0, 0, 0, 4'h1, 100, 624, 110, 1, 0, "wrap_dcf");
    vecs[3]  = mk(600, 0, 0, 0, 4'h1, 100, 60, 110, 0, 0, "wrap_miss");
    vecs[4]  = mk(0, 150, 400, 600, 4'hF, 100, 200, 140, 0, 0, "lane_miss");
    vecs[5]  = mk(0, 150, 400, 600, 4'hF, 100, 200, 131, 1, 1, "lane_bottom");
    vecs[6]  = mk(0, 150, 400, 600, 4'hF, 100, 200, 132, 0, 0, "lane_below");
    vecs[7]  = mk(0, 150, 400, 600, 4'hF, 100, 200, 99, 0, 0, "lane_above");
    vecs[8]  = mk(0, 150, 400, 600, 4'hF, 100, 200, 100, 1, 1, "lane_top");
    vecs[9]  = mk(0, 0, 700, 0, 4'h4, 100, 70, 110, 0, 0, "car_x_oob");
    vecs[10] = mk(600, 0, 0, 0, 4'h1, 100, 640, 110, 0, 0, "frog_x_oob");
    vecs[11] = mk(639, 0, 0, 0, 4'h1, 100, 0, 110, 1, 0, "edge_639");
    vecs[12] = mk(400, 100, 300, 90, 4'hF, 100, 120, 110, 1, 1, "multi_hit");
    vecs[13] = mk(0, 200, 0, 0, 4'h2, 100, 263, 110, 1, 1, "dfc_63");
    vecs[14] = mk(0, 200, 0, 0, 4'h2, 100, 264, 110, 0, 0, "dfc_64");
    vecs[15] = mk(0, 200, 0, 0, 4'h2, 100, 169, 110, 1, 1, "dcf_31");
    vecs[16] = mk(0, 200, 0, 0, 4'h2, 100, 168, 110, 0, 0, "dcf_32");
    vecs[17] = mk(0, 150, 400, 600, 4'hD, 100, 200, 110, 0, 0, "car_disabled");
    vecs[18] = mk(0, 0, 0, 205, 4'h8, 100, 200, 110, 1, 3, "car3_only");

    // Reset with frame_clk held high must not produce a scan afterwards.
    Reset   = 1'b1;
    Hit_Ack = 1'b0;
    frame_clk = 1'b1;
    drive(vecs[0]);
    repeat (3) @(negedge Clk);
    chk("rst frog_hit", 32'(Frog_Hit), 32'd0);
    chk("rst hit_car", 32'(Hit_Car), 32'd0);
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst overrun", 32'(Overrun), 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("post_rst no_scan", 32'(Busy), 32'd0);
    frame_clk = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], 0);

    // Second edge three cycles after the first is dropped; result unaffected.
    run_vec(vecs[0], 3);
    chk("overrun sticky", 32'(Overrun), 32'd1);
    run_vec(vecs[3], 0);
    chk("overrun sticky2", 32'(Overrun), 32'd1);

    // Reset during SCAN with frame_clk held high.
    drive(vecs[0]);
    frame_clk = 1'b1;
    @(negedge Clk);
    chk("midrst busy", 32'(Busy), 32'd1);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst frog_hit", 32'(Frog_Hit), 32'd0);
    chk("midrst hit_car", 32'(Hit_Car), 32'd0);
    chk("midrst busy0", 32'(Busy), 32'd0);
    chk("midrst overrun", 32'(Overrun), 32'd0);
    repeat (8) @(negedge Clk);
    chk("midrst no_scan busy", 32'(Busy), 32'd0);
    chk("midrst no_scan hit", 32'(Frog_Hit), 32'd0);
    frame_clk = 1'b0;
    @(negedge Clk);
    run_vec(vecs[12], 0);
    chk("final overrun", 32'(Overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/car_collide.md
# car_collide

Per-row collision detector sitting directly downstream of the car row motion stage. On each frame tick it snapshots the row's car X positions, the row Y, and the frog position. It then scans the cars one per clock through a single shared overlap comparator, with horizontal wrap-around at the screen edge. A hit is reported to the game controller and held until acknowledged.

## Interface
Parameters:
- NUM_CARS, 4: cars per row (1–4).
- CAR_W, 64: car width in pixels.
- FROG_W, 32: frog width in pixels.
- ROW_H, 32: lane height in pixels.
- SCREEN_W, 640: visible width; X wraps modulo this.

Ports:
- Clk, input, 1: system clock. One clock domain. Reset is synchronous and active-high.
- Reset, input, 1: synchronous, active-high.
- frame_clk, input, 1: frame tick level, sampled on Clk. Its rising edge starts a scan.
- Car_X, input, [NUM_CARS-1:0][10:0]: car left-edge X from the car row stage.
- Car_Valid, input, NUM_CARS: per-car enable. This is the lower Number_Cars bits of the row config.
- CarY, input, 11: top Y of the row.
- FrogX, input, 11: frog left-edge X.
- FrogY, input, 11: frog top Y.
- Hit_Ack, input, 1: controller acknowledge of a hit.
- Frog_Hit, output, 1: collision pending. Reset value 0.
- Hit_Car, output, $clog2(NUM_CARS) (minimum 1): lowest colliding car index. Reset value 0.
- Busy, output, 1: scan in progress. Reset value 0.
- Overrun, output, 1: sticky flag, set when a frame edge arrives while not IDLE. Reset value 0.

## Operation
- Edge detect uses register fc_q. An edge is `frame_clk & ~fc_q`. Reset loads fc_q with the current frame_clk, so no spurious edge appears after reset.
- States:
  - **IDLE**: wait for an edge. On an edge, snapshot all inputs, set idx=0 and hit_found=0, go to SCAN.
  - **SCAN**: evaluate car idx each cycle. If it hits and hit_found=0, record idx and set hit_found. After idx=NUM_CARS-1, go to REPORT.
  - **REPORT**: one cycle. If hit_found, assert Frog_Hit, load Hit_Car, go to HOLD. Otherwise return to IDLE with Frog_Hit=0.
  - **HOLD**: Frog_Hit stays 1 until Hit_Ack is sampled 1. Then go to IDLE with Frog_Hit cleared on the same edge.
- Hit_Ack outside HOLD is ignored.
- A frame edge in SCAN, REPORT or HOLD is dropped and sets Overrun. In IDLE with Hit_Ack high on the same cycle, the edge is accepted.
- Vertical match: FrogY ≥ CarY and FrogY < CarY + ROW_H. Use 12-bit math so there is no overflow.
- Horizontal match on a circle of length SCREEN_W, with f=FrogX and c=Car_X[idx]:
  - Compute dfc = (f − c) mod SCREEN_W and dcf = (c − f) mod SCREEN_W. Compute each in 12 bits; add SCREEN_W if the result is negative.
  - Hit when dfc < CAR_W or dcf < FROG_W.
- A car is hit when Car_Valid[idx] is set, the vertical match holds, the horizontal match holds, and Car_X[idx] < SCREEN_W. A car with Car_X ≥ SCREEN_W is treated as invalid.
- FrogX ≥ SCREEN_W means no hit for any car.
- Busy is 1 in SCAN and REPORT.
- Reset in any state: return to IDLE. All outputs go to reset values, including Overrun.

## Timing
- Let the edge be detected at Clk edge t. Car 0 is compared in cycle t+1 and car k in t+1+k.
- REPORT occupies cycle t+1+NUM_CARS. Frog_Hit is visible from t+2+NUM_CARS, a latency of NUM_CARS+2 cycles; the value is 6 for NUM_CARS=4.
- Min back-to-back frame edge spacing for a no-hit result: NUM_CARS+2 cycles.
- Hit_Ack sampled 1 at edge a: Frog_Hit reads 0 from a+1.
- Inputs may change during SCAN. Only the snapshot is used.

## Structure
- Shared package `frogger_pkg`:
  - Constants SCREEN_W, ROW_H, CAR_W, FROG_W.
  - Enum `coll_state_t` {IDLE, SCAN, REPORT, HOLD}.
- Sub-module `wrap_overlap`, combinational: inputs f, c, widths and SCREEN_W; output hit. Instantiate it once and share it across cars by time-multiplexing.

## Test plan
- **Basic hit.** NUM_CARS=4, CarY=100, FrogY=110, FrogX=200, Car_X={0,150,400,600}, all valid. Pulse frame_clk. Expect: Frog_Hit=1 and Hit_Car=1 exactly 6 cycles after the detected edge. Frog_Hit holds until Hit_Ack, then drops the next cycle.
- **Wrap-around.** FrogX=10, Car_X[0]=600 (dfc=50<64), others invalid. Expect: hit on car 0. Repeat with FrogX=624, Car_X[0]=0 (dcf=16<32). Expect: hit. Repeat with FrogX=60, Car_X[0]=600 (dfc=100). Expect: no hit, back to IDLE after REPORT.
- **Lane miss and invalid.** FrogY=140 with CarY=100. Expect: no hit. Separately, Car_X[2]=700 overlapping in X. Expect: ignored as invalid.
- **Overrun.** Raise frame_clk edges 3 cycles apart. Expect: the second edge is dropped, Overrun=1 and sticky, and the first scan result is unaffected.
- **Reset mid-operation.** Assert Reset in SCAN with frame_clk held high. Expect: all outputs 0 the next cycle, and no new scan until frame_clk falls and rises again.
- **Multi-hit priority.** Cars 1 and 3 overlapping. Expect: Hit_Car=1. Changing the inputs during SCAN does not alter the result.
